// File: rtl/id_stage_unit_pkg.sv
// Shared widths, instruction field codes and the condition evaluator
// used by the ARM instruction-decode stage.
package id_stage_unit_pkg;

    localparam int ADDRESS_LEN     = 32;
    localparam int INSTRUCTION_LEN = 32;
    localparam int REG_COUNT       = 15;
    localparam logic [3:0] PC_REG  = 4'd15;

    typedef enum logic [1:0] {
        MODE_ARITH  = 2'b00,
        MODE_MEM    = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_NONE   = 2'b11
    } mode_t;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_EOR = 4'b0001,
        OP_SUB = 4'b0010,
        OP_ADD = 4'b0100,
        OP_ADC = 4'b0101,
        OP_SBC = 4'b0110,
        OP_TST = 4'b1000,
        OP_CMP = 4'b1010,
        OP_ORR = 4'b1100,
        OP_MOV = 4'b1101,
        OP_MVN = 4'b1111
    } opcode_t;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic       imm;
    } ctrl_t;

    // Flags arrive as {N,Z,C,V}; the NV encoding never executes.
    function automatic logic cond_passed(input logic [3:0] cond, input logic [3:0] status);
        logic n, z, c, v;
        logic result;
        n = status[3];
        z = status[2];
        c = status[1];
        v = status[0];
        case (cond)
            COND_EQ: result = z;
            COND_NE: result = ~z;
            COND_CS: result = c;
            COND_CC: result = ~c;
            COND_MI: result = n;
            COND_PL: result = ~n;
            COND_VS: result = v;
            COND_VC: result = ~v;
            COND_HI: result = c & ~z;
            COND_LS: result = ~c | z;
            COND_GE: result = (n == v);
            COND_LT: result = (n != v);
            COND_GT: result = ~z & (n == v);
            COND_LE: result = z | (n != v);
            COND_AL: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/id_stage_unit_regfile.sv
// General-purpose register file R0..R14 with two combinational read ports,
// same-cycle write-through, and address 15 aliased to the current PC.
module id_register_file
    import id_stage_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             rd_addr1,
    input  logic [3:0]             rd_addr2,
    input  logic [ADDRESS_LEN-1:0] pc,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [31:0]            wr_data,
    output logic [31:0]            rd_data1,
    output logic [31:0]            rd_data2
);

    logic [31:0] regs [REG_COUNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != PC_REG) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A write landing this cycle is forwarded so the decoder never sees stale data.
    always_comb begin
        if (rd_addr1 == PC_REG) begin
            rd_data1 = pc;
        end else if (wr_en && wr_addr == rd_addr1) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = regs[rd_addr1];
        end
    end

    always_comb begin
        if (rd_addr2 == PC_REG) begin
            rd_data2 = pc;
        end else if (wr_en && wr_addr == rd_addr2) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = regs[rd_addr2];
        end
    end

endmodule

// File: rtl/id_stage_unit.sv
// Instruction-decode stage: decodes the fetched instruction, reads operands,
// evaluates the condition code and latches everything into the ID/EX register.
module id_stage_unit
    import id_stage_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze_in,
    input  logic                       flush_in,
    input  logic                       hazard_in,
    input  logic [ADDRESS_LEN-1:0]     pc_in,
    input  logic [INSTRUCTION_LEN-1:0] instruction_in,
    input  logic [3:0]                 status_in,
    input  logic                       wb_en_in,
    input  logic [3:0]                 wb_dest_in,
    input  logic [31:0]                wb_value_in,
    output logic [3:0]                 src1_out,
    output logic [3:0]                 src2_out,
    output logic                       two_src_out,
    output logic [ADDRESS_LEN-1:0]     pc_out,
    output logic [31:0]                val_rn_out,
    output logic [31:0]                val_rm_out,
    output logic                       imm_out,
    output logic                       s_out,
    output logic                       b_out,
    output logic                       mem_r_en_out,
    output logic                       mem_w_en_out,
    output logic                       wb_en_out,
    output logic [3:0]                 exe_cmd_out,
    output logic [11:0]                shift_operand_out,
    output logic [23:0]                signed_imm24_out,
    output logic [3:0]                 dest_out,
    output logic                       carry_out
);

    logic [3:0]  cond;
    logic [1:0]  mode;
    logic        imm_bit;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic        is_store;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    ctrl_t       decoded;
    ctrl_t       ctrl;

    assign cond     = instruction_in[31:28];
    assign mode     = instruction_in[27:26];
    assign imm_bit  = instruction_in[25];
    assign opcode   = instruction_in[24:21];
    assign s_bit    = instruction_in[20];
    assign rn       = instruction_in[19:16];
    assign rd       = instruction_in[15:12];
    assign rm       = instruction_in[3:0];

    // STR needs Rd as a data source, so the hazard unit must see it as src2.
    assign is_store    = (mode == MODE_MEM) && !s_bit;
    assign src1_out    = rn;
    assign src2_out    = is_store ? rd : rm;
    assign two_src_out = ~imm_bit | is_store;

    id_register_file u_register_file (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (src1_out),
        .rd_addr2 (src2_out),
        .pc       (pc_in),
        .wr_en    (wb_en_in),
        .wr_addr  (wb_dest_in),
        .wr_data  (wb_value_in),
        .rd_data1 (val_rn),
        .rd_data2 (val_rm)
    );

    always_comb begin
        decoded = '0;
        case (mode)
            MODE_ARITH: begin
                decoded.imm   = imm_bit;
                decoded.s     = s_bit;
                decoded.wb_en = 1'b1;
                case (opcode)
                    OP_MOV: decoded.exe_cmd = EXE_MOV;
                    OP_MVN: decoded.exe_cmd = EXE_MVN;
                    OP_ADD: decoded.exe_cmd = EXE_ADD;
                    OP_ADC: decoded.exe_cmd = EXE_ADC;
                    OP_SUB: decoded.exe_cmd = EXE_SUB;
                    OP_SBC: decoded.exe_cmd = EXE_SBC;
                    OP_AND: decoded.exe_cmd = EXE_AND;
                    OP_ORR: decoded.exe_cmd = EXE_ORR;
                    OP_EOR: decoded.exe_cmd = EXE_EOR;
                    OP_CMP: begin
                        decoded.exe_cmd = EXE_SUB;
                        decoded.wb_en   = 1'b0;
                    end
                    OP_TST: begin
                        decoded.exe_cmd = EXE_AND;
                        decoded.wb_en   = 1'b0;
                    end
                    default: decoded = '0;
                endcase
            end
            MODE_MEM: begin
                decoded.imm      = imm_bit;
                decoded.s        = s_bit;
                decoded.exe_cmd  = EXE_ADD;
                decoded.mem_r_en = s_bit;
                decoded.wb_en    = s_bit;
                decoded.mem_w_en = ~s_bit;
            end
            MODE_BRANCH: decoded.b = 1'b1;
            default: decoded = '0;
        endcase
    end

    // A failed condition squashes every side effect but leaves the operand fields intact.
    always_comb begin
        ctrl = decoded;
        if (!cond_passed(cond, status_in)) begin
            ctrl.exe_cmd  = EXE_NOP;
            ctrl.wb_en    = 1'b0;
            ctrl.mem_r_en = 1'b0;
            ctrl.mem_w_en = 1'b0;
            ctrl.b        = 1'b0;
            ctrl.s        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_in) begin
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            shift_operand_out <= '0;
            signed_imm24_out  <= '0;
            dest_out          <= '0;
            carry_out         <= 1'b0;
            imm_out           <= 1'b0;
            s_out             <= 1'b0;
            b_out             <= 1'b0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            wb_en_out         <= 1'b0;
            exe_cmd_out       <= '0;
        end else if (!freeze_in) begin
            pc_out            <= pc_in;
            val_rn_out        <= val_rn;
            val_rm_out        <= val_rm;
            shift_operand_out <= instruction_in[11:0];
            signed_imm24_out  <= instruction_in[23:0];
            dest_out          <= rd;
            carry_out         <= status_in[1];
            if (hazard_in) begin
                imm_out      <= 1'b0;
                s_out        <= 1'b0;
                b_out        <= 1'b0;
                mem_r_en_out <= 1'b0;
                mem_w_en_out <= 1'b0;
                wb_en_out    <= 1'b0;
                exe_cmd_out  <= '0;
            end else begin
                imm_out      <= ctrl.imm;
                s_out        <= ctrl.s;
                b_out        <= ctrl.b;
                mem_r_en_out <= ctrl.mem_r_en;
                mem_w_en_out <= ctrl.mem_w_en;
                wb_en_out    <= ctrl.wb_en;
                exe_cmd_out  <= ctrl.exe_cmd;
            end
        end
    end

endmodule
